ball_physics_sequencer: RTL

//  Owns breakout ball state: position, velocity direction and the 5x12 brick hit map.
//  On each game tick it runs one fixed sequence: move, resolve walls/paddle/floor, scan bricks one per cycle, commit.

---
 rtl/ball_physics_sequencer.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/ball_physics_sequencer.sv
// rtl/ball_physics_sequencer.sv - breakout ball move/bounce/brick-scan sequencer, one pass per game tick
// Optional PADDLE_SPIN_EN: a paddle bounce steers vx_neg by the hit offset from the paddle centre.
module ball_physics_sequencer #(
  parameter int LEFT_WALL_X   = 144,
  parameter int RIGHT_WALL_X  = 783,
  parameter int CEILING_Y     = 35,
  parameter int FLOOR_Y       = 515,
  parameter int BLOCK_WIDTH   = 53,
  parameter int BLOCK_HEIGHT  = 25,
  parameter int COLS          = 12,
  parameter int ROWS          = 5,
  parameter int BALL_HALF     = 5,
  parameter int PADDLE_HALF_W = 25,
  parameter int PADDLE_HALF_H = 5,
  parameter int SPEED         = 2,
  parameter int BALL_X0       = 450,
  parameter int BALL_Y0       = 480
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 run,
  input  logic [9:0]           paddle_x,
  input  logic [9:0]           paddle_y,
  input  logic                 load,
  input  logic [9:0]           load_x,
  input  logic [9:0]           load_y,
  input  logic                 load_vx_neg,
  input  logic                 load_vy_neg,
  output logic [9:0]           ball_x,
  output logic [9:0]           ball_y,
  output logic                 vx_neg,
  output logic                 vy_neg,
  output logic [COLS*ROWS-1:0] hit_map,
  output logic [7:0]           score,
  output logic                 busy,
  output logic                 done,
  output logic                 brick_hit,
  output logic                 miss,
  output logic                 all_clear
);
  localparam int NB = COLS * ROWS;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [10:0] SPD       = 11'(SPEED);
  localparam logic [10:0] HALF      = 11'(BALL_HALF);
  localparam logic [10:0] LEFT_LIM  = 11'(LEFT_WALL_X + BALL_HALF);
  localparam logic [10:0] RIGHT_LIM = 11'(RIGHT_WALL_X - BALL_HALF);
  localparam logic [10:0] CEIL_LIM  = 11'(CEILING_Y + BALL_HALF);
  localparam logic [10:0] FLOOR_LIM = 11'(FLOOR_Y);
  localparam logic [10:0] PAD_XR    = 11'(PADDLE_HALF_W + BALL_HALF);
  localparam logic [10:0] PAD_YR    = 11'(PADDLE_HALF_H + BALL_HALF);
  localparam logic [10:0] BRK_XR    = 11'(BLOCK_WIDTH - 1 + BALL_HALF);
  localparam logic [10:0] BRK_YR    = 11'(BLOCK_HEIGHT - 1 + BALL_HALF);

  typedef enum logic [2:0] {S_IDLE, S_MOVE, S_BOUND, S_SCAN, S_COMMIT} state_t;

  state_t          state_q;
  logic [9:0]      ball_x_q, ball_y_q;
  logic            vx_q, vy_q;
  logic [NB-1:0]   hit_map_q;
  logic [7:0]      score_q;
  logic            busy_q, done_q, brick_hit_q, miss_q;
  logic [10:0]     nx_q, ny_q, nx_d, ny_d, mv_x, mv_y;
  logic            nvx_q, nvy_q, nvx_d, nvy_d, nmiss_q, miss_d;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;
  logic [IW-1:0]   idx_q, hit_idx_q;
  logic            found_q;
  logic [10:0]     px, py, bx0, by0;
  logic            brick_ov;

  assign px = {1'b0, paddle_x};
  assign py = {1'b0, paddle_y};

  // Subtraction saturates at zero so the 11-bit position never wraps.
  always_comb begin
    mv_x = {1'b0, ball_x_q} + SPD;
    mv_y = {1'b0, ball_y_q} + SPD;
    if (vx_q) mv_x = ({1'b0, ball_x_q} < SPD) ? 11'd0 : {1'b0, ball_x_q} - SPD;
    if (vy_q) mv_y = ({1'b0, ball_y_q} < SPD) ? 11'd0 : {1'b0, ball_y_q} - SPD;
  end

  always_comb begin
    nx_d   = nx_q;
    ny_d   = ny_q;
    nvx_d  = nvx_q;
    nvy_d  = nvy_q;
    miss_d = 1'b0;
    if (ny_q + HALF >= FLOOR_LIM) begin
      miss_d = 1'b1;
      nx_d   = 11'(BALL_X0);
      ny_d   = 11'(BALL_Y0);
      nvx_d  = 1'b0;
      nvy_d  = 1'b1;
    end else begin
      if (nx_q <= LEFT_LIM) begin
        nx_d  = LEFT_LIM + 11'd1;
        nvx_d = 1'b0;
      end else if (nx_q >= RIGHT_LIM) begin
        nx_d  = RIGHT_LIM - 11'd1;
        nvx_d = 1'b1;
      end
      if (ny_q <= CEIL_LIM) begin
        ny_d  = CEIL_LIM + 11'd1;
        nvy_d = 1'b0;
      end
      if (!nvy_d && (nx_d + PAD_XR >= px) && (nx_d <= px + PAD_XR) &&
          (ny_d + PAD_YR >= py) && (ny_d <= py + PAD_YR)) begin
        nvy_d = 1'b1;
        ny_d  = py - PAD_YR - 11'd1;
`ifdef PADDLE_SPIN_EN
        if (nx_d + 11'd8 < px) nvx_d = 1'b1;
        else if (nx_d > px + 11'd8) nvx_d = 1'b0;
`endif
      end
    end
  end

  always_comb begin
    bx0      = 11'(LEFT_WALL_X + int'(col_q) * BLOCK_WIDTH);
    by0      = 11'(CEILING_Y + int'(row_q) * BLOCK_HEIGHT);
    brick_ov = (nx_q + HALF >= bx0) && (nx_q <= bx0 + BRK_XR) &&
               (ny_q + HALF >= by0) && (ny_q <= by0 + BRK_YR);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ball_x_q    <= 10'(BALL_X0);
      ball_y_q    <= 10'(BALL_Y0);
      vx_q        <= 1'b0;
      vy_q        <= 1'b0;
      hit_map_q   <= '0;
      score_q     <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      brick_hit_q <= 1'b0;
      miss_q      <= 1'b0;
      nx_q        <= 11'd0;
      ny_q        <= 11'd0;
      nvx_q       <= 1'b0;
      nvy_q       <= 1'b0;
      nmiss_q     <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      idx_q       <= '0;
      hit_idx_q   <= '0;
      found_q     <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      brick_hit_q <= 1'b0;
      miss_q      <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (load) begin
            ball_x_q <= load_x;
            ball_y_q <= load_y;
            vx_q     <= load_vx_neg;
            vy_q     <= load_vy_neg;
          end else if (tick && run && !all_clear) begin
            state_q <= S_MOVE;
            busy_q  <= 1'b1;
          end
        end
        S_MOVE: begin
          nx_q    <= mv_x;
          ny_q    <= mv_y;
          nvx_q   <= vx_q;
          nvy_q   <= vy_q;
          state_q <= S_BOUND;
        end
        S_BOUND: begin
          nx_q    <= nx_d;
          ny_q    <= ny_d;
          nvx_q   <= nvx_d;
          nvy_q   <= nvy_d;
          nmiss_q <= miss_d;
          found_q <= 1'b0;
          col_q   <= '0;
          row_q   <= '0;
          idx_q   <= '0;
          state_q <= S_SCAN;
        end
        S_SCAN: begin
          // Only the first overlapping live brick counts; a miss skips brick hits entirely.
          if (!nmiss_q && !found_q && brick_ov && !hit_map_q[idx_q]) begin
            found_q   <= 1'b1;
            hit_idx_q <= idx_q;
          end
          idx_q <= idx_q + 1'b1;
          if (col_q == CW'(COLS - 1)) begin
            col_q <= '0;
            row_q <= row_q + 1'b1;
          end else begin
            col_q <= col_q + 1'b1;
          end
          if (idx_q == IW'(NB - 1)) state_q <= S_COMMIT;
        end
        S_COMMIT: begin
          ball_x_q    <= nx_q[9:0];
          ball_y_q    <= ny_q[9:0];
          vx_q        <= nvx_q;
          vy_q        <= nvy_q ^ found_q;
          if (found_q) begin
            hit_map_q[hit_idx_q] <= 1'b1;
            score_q              <= score_q + 8'd1;
          end
          brick_hit_q <= found_q;
          miss_q      <= nmiss_q;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ball_x    = ball_x_q;
  assign ball_y    = ball_y_q;
  assign vx_neg    = vx_q;
  assign vy_neg    = vy_q;
  assign hit_map   = hit_map_q;
  assign score     = score_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign brick_hit = brick_hit_q;
  assign miss      = miss_q;
  assign all_clear = &hit_map_q;
endmodule
